ram_rd_chk: RTL

Port-B read-and-check engine for the dual-port RAM test design. It is the counterpart of the port-A writer, which fills 64 locations with data equal to the zero-extended address and raises a sticky `rd_flag` once it is half-way through the array. After `rd_flag` rises, this block sweeps the RAM by address. It compares each returned word against the expected pattern and reports per-word results, an error count, the number of completed passes, and a done indication.

---
 rtl/ram_rd_chk.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_rd_chk.sv
// ram_rd_chk - port-B read-and-check engine for the dual-port RAM test design.
//
// Once the port-A writer raises rd_flag, this block sweeps the RAM by address,
// one read per cycle. It compares each returned word against the pattern the
// writer stores (data = zero-extended address) and reports per-word results,
// a saturating error count, the number of completed passes and a done flag.
//
// Build option:
//   RAM_RD_CHK_STOP_ON_ERR_EN - when defined, the first mismatch seen in READ
//   or DRAIN parks the FSM in HALT. Reads stop, compares already in flight are
//   still counted, ram_rd_addr keeps the last issued address and done stays 0.
//   When undefined, mismatches are only counted and the sweep continues.
//
// Parameters:
//   ADDR_W   - RAM address width; one pass is 2**ADDR_W reads
//   DATA_W   - RAM data width (>= ADDR_W)
//   RD_LAT   - RAM read latency in cycles (1 or 2)
//   PASS_CNT - full passes before done; 0 = run forever
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   rd_flag      in   level-sensitive start/permit from the writer
//   ram_rd_en    out  port-B read enable (registered)
//   ram_rd_addr  out  port-B read address (registered)
//   ram_rd_data  in   port-B read data, RD_LAT cycles after the address
//   chk_valid    out  one-cycle pulse per completed compare
//   chk_err      out  mismatch flag, qualified by chk_valid
//   err_sticky   out  set on the first mismatch, cleared only by rst
//   err_cnt      out  mismatch count, saturating
//   pass_cnt     out  completed passes, saturating
//   done         out  high in the DONE state
//
// FSM states:
//   state   | meaning
//   IDLE    | address held at 0, waiting for rd_flag
//   READ    | one read issued every cycle, address wraps
//   DRAIN   | no new reads, waiting for in-flight compares to finish
//   DONE    | pass target met, held until rst
//   HALT    | stopped on first mismatch (stop-on-error build only)

module ram_rd_chk #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int PASS_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_flag,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              chk_valid,
    output logic              chk_err,
    output logic              err_sticky,
    output logic [15:0]       err_cnt,
    output logic [7:0]        pass_cnt,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
`ifdef RAM_RD_CHK_STOP_ON_ERR_EN
        S_HALT  = 3'd4,
`endif
        S_DONE  = 3'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [7:0]        PASS_TGT = 8'(PASS_CNT);
    localparam bit                RUN_FOREVER = (PASS_CNT == 0);

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] issue_addr;     // next address READ will put out
    logic [7:0]        issue_pass;     // full passes whose last address has been issued

    logic [RD_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];

    logic              cmp_vld;
    logic              cmp_err;
    logic              cmp_last;
    logic [DATA_W-1:0] exp_data;
    logic              last_issue;
    logic              pipe_empty;
    logic              pass_met;
    logic              issue;
    logic              clr_addr;

    assign cmp_vld  = pipe_vld[RD_LAT-1];
    assign exp_data = DATA_W'(pipe_addr[RD_LAT-1]);
    assign cmp_err  = cmp_vld && (ram_rd_data != exp_data);
    assign cmp_last = cmp_vld && (pipe_addr[RD_LAT-1] == ADDR_MAX);

    // The final address of the final pass is issued on the edge this is true.
    assign last_issue = !RUN_FOREVER && (issue_addr == ADDR_MAX) &&
                        (issue_pass == PASS_TGT - 8'd1);

    // A read enable still sitting in the output register has not yet entered
    // the delay line, so it counts as in flight. The compare register itself
    // empties on the same edge that leaves DRAIN, which puts done exactly one
    // cycle after the last chk_valid.
    assign pipe_empty = !ram_rd_en && (pipe_vld == '0);
    assign pass_met   = !RUN_FOREVER && (pass_cnt >= PASS_TGT);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (rd_flag) next_state = S_READ;
            // rd_flag only steers the next state; the current READ cycle always
            // issues, so a drop coinciding with the final address still ends in DONE.
            S_READ:  if (last_issue || !rd_flag) next_state = S_DRAIN;
            S_DRAIN: if (pipe_empty) next_state = pass_met ? S_DONE : S_IDLE;
            S_DONE:  next_state = S_DONE;
`ifdef RAM_RD_CHK_STOP_ON_ERR_EN
            S_HALT:  next_state = S_HALT;
`endif
            default: next_state = S_IDLE;
        endcase
`ifdef RAM_RD_CHK_STOP_ON_ERR_EN
        if ((state == S_READ || state == S_DRAIN) && cmp_err) begin
            next_state = S_HALT;
        end
`endif
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        issue    = (state == S_READ);
        clr_addr = (next_state == S_IDLE);
        done     = (state == S_DONE);
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            issue_addr  <= '0;
            issue_pass  <= '0;
            pipe_vld    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr[i] <= '0;
            end
            chk_valid   <= 1'b0;
            chk_err     <= 1'b0;
            err_sticky  <= 1'b0;
            err_cnt     <= '0;
            pass_cnt    <= '0;
        end else begin
            if (issue) begin
                ram_rd_en   <= 1'b1;
                ram_rd_addr <= issue_addr;
                issue_addr  <= issue_addr + 1'b1;
                if (issue_addr == ADDR_MAX && issue_pass != 8'hFF) begin
                    issue_pass <= issue_pass + 8'd1;
                end
            end else begin
                ram_rd_en <= 1'b0;
                // Partial-pass progress is dropped on the way back to IDLE;
                // otherwise the address is left alone (HALT keeps it for debug).
                if (clr_addr) begin
                    ram_rd_addr <= '0;
                    issue_addr  <= '0;
                end
            end

            pipe_vld[0]  <= ram_rd_en;
            pipe_addr[0] <= ram_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end

            chk_valid <= cmp_vld;
            chk_err   <= cmp_err;
            if (cmp_err) begin
                err_sticky <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
            if (cmp_last && pass_cnt != 8'hFF) begin
                pass_cnt <= pass_cnt + 8'd1;
            end
        end
    end

endmodule
